// File: rtl/mult_acc_24.sv
// Sequential shift-add multiply-accumulate: result = q*d + r, one multiplier bit per cycle.
// Latency WIDTH cycles after accept; result held in DONE until out_ready, no new accept until then.
module mult_acc_24 #(
  parameter int WIDTH = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   quotient,
  input  logic [WIDTH-1:0]   divisor,
  input  logic [WIDTH-1:0]   remainder,
  input  logic [WIDTH-1:0]   numerator,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               overflow,
  output logic               match,
  output logic               err
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     num_q, num_d;
  logic                 err_pend_q, err_pend_d;
  logic [2*WIDTH-1:0]   result_q, result_d;
  logic                 overflow_q, overflow_d;
  logic                 match_q, match_d;
  logic                 err_q, err_d;
  logic                 in_ready_q, in_ready_d;
  logic                 out_valid_q, out_valid_d;

  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   acc_sum;

  // Multiplicand shifts left and multiplier shifts right so the active bit is always bit 0.
  assign partial = mplier_q[0] ? mcand_q : '0;
  assign acc_sum = acc_q + partial;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    num_d       = num_q;
    err_pend_d  = err_pend_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    match_d     = match_q;
    err_d       = err_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d    = MUL;
          cnt_d      = '0;
          mcand_d    = {{WIDTH{1'b0}}, quotient};
          mplier_d   = divisor;
          acc_d      = {{WIDTH{1'b0}}, remainder};
          num_d      = numerator;
          err_pend_d = (divisor == '0) || (remainder >= divisor);
          in_ready_d = 1'b0;
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          result_d    = acc_sum;
          overflow_d  = |acc_sum[2*WIDTH-1:WIDTH];
          match_d     = (acc_sum == {{WIDTH{1'b0}}, num_q});
          err_d       = err_pend_q;
        end
      end
      DONE: begin
        // Only the output handshake leaves DONE; in_valid is not looked at here.
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      num_q       <= '0;
      err_pend_q  <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      match_q     <= 1'b0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      num_q       <= num_d;
      err_pend_q  <= err_pend_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      match_q     <= match_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;
  assign match     = match_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mult_acc_24.sv
// Directed and random checks of mult_acc_24 against an arithmetic reference (q*d + r).
module tb_mult_acc_24;

  localparam int W = 24;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   quotient, divisor, remainder, numerator;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] result;
  logic           overflow, match, err;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mult_acc_24 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .numerator (numerator),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .match     (match),
    .err       (err)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present an operand set at a negedge and return one negedge after the accepting edge.
  task automatic start(input logic [W-1:0] q, input logic [W-1:0] d,
                       input logic [W-1:0] r, input logic [W-1:0] n, input bit hold);
    int t = 0;
    quotient = q; divisor = d; remainder = r; numerator = n;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("accept_ready", {63'b0, in_ready}, 64'd1);
    @(negedge clk);
    in_valid  = hold;
    quotient  = W'($urandom);
    divisor   = W'($urandom);
    remainder = W'($urandom);
    numerator = W'($urandom);
  endtask

  task automatic wait_done(input string tag);
    int lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd24);
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] q, input logic [W-1:0] d,
                           input logic [W-1:0] r, input logic [W-1:0] n);
    longint unsigned full;
    full = longint'(q) * longint'(d) + longint'(r);
    chk({tag, "_result"},   {16'b0, result},      full);
    chk({tag, "_overflow"}, {63'b0, overflow},    {63'b0, (full >= 64'h1000000)});
    chk({tag, "_match"},    {63'b0, match},       {63'b0, (full == longint'(n))});
    chk({tag, "_err"},      {63'b0, err},         {63'b0, (d == 0) || (r >= d)});
  endtask

  task automatic run(input string tag, input logic [W-1:0] q, input logic [W-1:0] d,
                     input logic [W-1:0] r, input logic [W-1:0] n);
    start(q, d, r, n, 1'b0);
    wait_done(tag);
    check_out(tag, q, d, r, n);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_post_ovalid"}, {63'b0, out_valid}, 64'd0);
    chk({tag, "_post_iready"}, {63'b0, in_ready}, 64'd1);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [2*W-1:0] snap_res;
    logic [2:0]     snap_flags;
    logic [W-1:0]   q, d, r, n;
    int unsigned    prev_cyc;

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    quotient = '0; divisor = '0; remainder = '0; numerator = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_result",    {16'b0, result},    64'd0);
    chk("rst_flags",     {61'b0, overflow, match, err}, 64'd0);

    run("basic", 24'd14, 24'd7, 24'd2, 24'd100);
    chk("basic_const", {16'b0, result}, 64'h64);
    run("ones", 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
    chk("ones_const", {16'b0, result}, 64'hFFFFFF000000);
    run("dzero", 24'd5, 24'd0, 24'd3, 24'd3);

    // Stall in DONE with a competing operand set offered.
    start(24'd100, 24'd200, 24'd50, 24'd20050, 1'b0);
    wait_done("stall");
    check_out("stall", 24'd100, 24'd200, 24'd50, 24'd20050);
    snap_res   = result;
    snap_flags = {overflow, match, err};
    in_valid = 1'b1; quotient = 24'd9; divisor = 24'd9; remainder = 24'd1; numerator = 24'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_ovalid", {63'b0, out_valid}, 64'd1);
      chk("stall_iready", {63'b0, in_ready}, 64'd0);
      chk("stall_result", {16'b0, result}, {16'b0, snap_res});
      chk("stall_flags",  {61'b0, overflow, match, err}, {61'b0, snap_flags});
    end
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    chk("stall_post_ovalid", {63'b0, out_valid}, 64'd0);
    chk("stall_post_iready", {63'b0, in_ready}, 64'd1);

    // Reset during MUL cycle 10 discards the transaction.
    start(W'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'b0);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_ovalid", {63'b0, out_valid}, 64'd0);
    chk("midrst_iready", {63'b0, in_ready}, 64'd1);
    chk("midrst_result", {16'b0, result}, 64'd0);
    run("after_rst", 24'd3, 24'd3, 24'd1, 24'd10);

    // Arbitrary operands, legal or not, with n sometimes equal to the true result.
    for (int i = 0; i < 4; i++) begin
      q = W'($urandom); d = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
      r = W'($urandom);
      n = (i % 2 == 0) ? W'(longint'(q) * longint'(d) + longint'(r)) : W'($urandom);
      run("rand", q, d, r, n);
    end

    // Back-to-back legal sets with in_valid and out_ready held high.
    out_ready = 1'b1;
    prev_cyc  = 0;
    for (int i = 0; i < 8; i++) begin
      int t = 0;
      q = W'($urandom_range(0, 4095));
      d = W'($urandom_range(1, 4095));
      r = W'($urandom_range(0, int'(d) - 1));
      n = W'(longint'(q) * longint'(d) + longint'(r));
      quotient = q; divisor = d; remainder = r; numerator = n;
      in_valid = 1'b1;
      while (!in_ready && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("b2b_accept", {63'b0, in_ready}, 64'd1);
      if (i > 0) chk("b2b_interval", 64'(cyc - prev_cyc), 64'd26);
      prev_cyc = cyc;
      @(negedge clk);
      quotient = W'($urandom); divisor = W'($urandom);
      wait_done("b2b");
      check_out("b2b", q, d, r, n);
      chk("b2b_match1", {63'b0, match}, 64'd1);
      @(negedge clk);
      chk("b2b_no_dup", {63'b0, out_valid}, 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
